// File: rtl/issue_scoreboard.sv
// Issue-stage controller: 31-entry pending-register scoreboard, RAW/WAW hazard stall,
// ALU/MDU dispatch and a two-state MDU sequencer with a watchdog.
module issue_scoreboard #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned MD_TMO = 64
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             DEC_VALID,
    output logic             DEC_READY,
    input  logic [4:0]       DEC_RS1,
    input  logic [4:0]       DEC_RS2,
    input  logic [4:0]       DEC_RD,
    input  logic             DEC_IS_MD,
    input  logic             FLUSH,
    output logic             ALU_ISSUE,
    output logic             MD_ISSUE,
    input  logic             MD_DONE,
    input  logic             WB_VALID,
    input  logic [4:0]       WB_RD,
    output logic             MD_BUSY_O,
    output logic             MD_ERR,
    output logic [CNT_W-1:0] STALL_CNT
);

    localparam int unsigned TW = (MD_TMO > 1) ? $clog2(MD_TMO) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(MD_TMO - 1);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    md_state_t      state;
    logic [31:0]    pend;
    logic [4:0]     md_rd;
    logic [TW-1:0]  tmo;

    logic [31:0]    clr;
    logic [31:0]    eff;
    logic [31:0]    set_oh;
    logic           hazard;
    logic           md_retire;
    logic           stall;

    // MD_DONE only retires md_rd while busy; a stray pulse in MD_IDLE is ignored.
    always_comb begin
        md_retire = MD_DONE && (state == MD_BUSY);
        clr       = '0;
        if (WB_VALID)  clr = clr | (32'd1 << WB_RD);
        if (md_retire) clr = clr | (32'd1 << md_rd);
        eff       = pend & ~clr;
        hazard    = eff[DEC_RS1] | eff[DEC_RS2] | eff[DEC_RD];
        DEC_READY = DEC_VALID && !FLUSH && !hazard && !MD_ERR
                    && !(DEC_IS_MD && (state == MD_BUSY));
        ALU_ISSUE = DEC_READY && !DEC_IS_MD;
        MD_ISSUE  = DEC_READY && DEC_IS_MD;
        set_oh    = '0;
        if (DEC_READY && (DEC_RD != 5'd0)) set_oh = 32'd1 << DEC_RD;
        stall     = DEC_VALID && !DEC_READY && !FLUSH;
    end

    assign MD_BUSY_O = (state == MD_BUSY);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= MD_IDLE;
            pend      <= '0;
            md_rd     <= '0;
            tmo       <= '0;
            MD_ERR    <= 1'b0;
            STALL_CNT <= '0;
        end else begin
            // Set is ORed after the clear so a same-cycle reissue to a retiring rd stays pending.
            pend <= ((pend & ~clr) | set_oh) & ~32'd1;

            if (stall && (STALL_CNT != '1))
                STALL_CNT <= STALL_CNT + 1'b1;

            case (state)
                MD_IDLE: begin
                    if (MD_ISSUE) begin
                        state <= MD_BUSY;
                        md_rd <= DEC_RD;
                        tmo   <= '0;
                    end
                end
                MD_BUSY: begin
                    if (MD_DONE) begin
                        state <= MD_IDLE;
                    end else if (tmo == TMO_LAST) begin
                        MD_ERR <= 1'b1;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: hazard stalls, MDU sequencing, watchdog, counter saturation.
module tb_issue_scoreboard;

    localparam int unsigned CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RSTN;
    logic             DEC_VALID;
    logic             DEC_READY;
    logic [4:0]       DEC_RS1;
    logic [4:0]       DEC_RS2;
    logic [4:0]       DEC_RD;
    logic             DEC_IS_MD;
    logic             FLUSH;
    logic             ALU_ISSUE;
    logic             MD_ISSUE;
    logic             MD_DONE;
    logic             WB_VALID;
    logic [4:0]       WB_RD;
    logic             MD_BUSY_O;
    logic             MD_ERR;
    logic [CNT_W-1:0] STALL_CNT;

    int vectors = 0;
    int errs    = 0;

    issue_scoreboard #(.CNT_W(CNT_W), .MD_TMO(64)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .DEC_VALID(DEC_VALID), .DEC_READY(DEC_READY),
        .DEC_RS1(DEC_RS1), .DEC_RS2(DEC_RS2), .DEC_RD(DEC_RD),
        .DEC_IS_MD(DEC_IS_MD), .FLUSH(FLUSH),
        .ALU_ISSUE(ALU_ISSUE), .MD_ISSUE(MD_ISSUE),
        .MD_DONE(MD_DONE), .WB_VALID(WB_VALID), .WB_RD(WB_RD),
        .MD_BUSY_O(MD_BUSY_O), .MD_ERR(MD_ERR), .STALL_CNT(STALL_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Applies a full input vector and lets the combinational outputs settle.
    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic md, input logic fl,
                         input logic wbv, input logic [4:0] wbrd, input logic mdd);
        DEC_VALID = v;  DEC_RS1 = rs1; DEC_RS2 = rs2; DEC_RD = rd;
        DEC_IS_MD = md; FLUSH = fl;    WB_VALID = wbv; WB_RD = wbrd; MD_DONE = mdd;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        idle();
        RSTN = 1'b0;
        tick();
        RSTN = 1'b1;
        #1;
    endtask

    task automatic chk_issue(input string tag, input logic rdy, input logic alu, input logic md);
        check({tag, ".ready"}, 32'(DEC_READY), 32'(rdy));
        check({tag, ".alu"},   32'(ALU_ISSUE), 32'(alu));
        check({tag, ".md"},    32'(MD_ISSUE),  32'(md));
    endtask

    initial begin
        RSTN = 1'b0;
        idle();
        #2;
        check("rst.ready", 32'(DEC_READY), 0);
        check("rst.busy",  32'(MD_BUSY_O), 0);
        check("rst.err",   32'(MD_ERR),    0);
        check("rst.stall", 32'(STALL_CNT), 0);
        drive(1, 0, 0, 5, 0, 0, 0, 0, 0);
        check("rst.held_ready", 32'(DEC_READY), 1);
        tick();
        do_reset();

        // 1: addi x5; add x6,x5,x1 stalls until WB x5, issuing in the WB cycle
        drive(1, 0, 0, 5, 0, 0, 0, 0, 0);
        chk_issue("t1.addi", 1, 1, 0);
        tick();
        drive(1, 5, 1, 6, 0, 0, 0, 0, 0);
        chk_issue("t1.add_stall", 0, 0, 0);
        tick();
        check("t1.stall1", 32'(STALL_CNT), 1);
        tick();
        check("t1.stall2", 32'(STALL_CNT), 2);
        drive(1, 5, 1, 6, 0, 0, 1, 5, 0);
        chk_issue("t1.add_bypass", 1, 1, 0);
        tick();
        check("t1.stall_hold", 32'(STALL_CNT), 2);
        drive(1, 6, 0, 10, 0, 0, 0, 0, 0);
        check("t1.x6_pending", 32'(DEC_READY), 0);
        drive(1, 5, 0, 10, 0, 0, 0, 0, 0);
        check("t1.x5_cleared", 32'(DEC_READY), 1);
        do_reset();

        // 2: div x7 busy; ALU add proceeds; mul x9 waits for MD_DONE then issues next cycle
        drive(1, 3, 4, 7, 1, 0, 0, 0, 0);
        chk_issue("t2.div", 1, 0, 1);
        tick();
        check("t2.busy", 32'(MD_BUSY_O), 1);
        drive(1, 1, 2, 8, 0, 0, 0, 0, 0);
        chk_issue("t2.add", 1, 1, 0);
        tick();
        drive(1, 1, 2, 9, 1, 0, 0, 0, 0);
        chk_issue("t2.mul_stall", 0, 0, 0);
        tick();
        tick();
        drive(1, 1, 2, 9, 1, 0, 0, 0, 1);
        chk_issue("t2.mul_done_cycle", 0, 0, 0);
        tick();
        check("t2.idle", 32'(MD_BUSY_O), 0);
        check("t2.stall3", 32'(STALL_CNT), 3);
        drive(1, 1, 2, 9, 1, 0, 0, 0, 0);
        chk_issue("t2.mul_issue", 1, 0, 1);
        tick();
        check("t2.busy_again", 32'(MD_BUSY_O), 1);
        do_reset();

        // 3: div x7 then addi x7 (WAW); issues in the MD_DONE cycle and x7 stays pending
        drive(1, 1, 2, 7, 1, 0, 0, 0, 0);
        chk_issue("t3.div", 1, 0, 1);
        tick();
        drive(1, 0, 0, 7, 0, 0, 0, 0, 0);
        chk_issue("t3.waw_stall", 0, 0, 0);
        tick();
        drive(1, 0, 0, 7, 0, 0, 0, 0, 1);
        chk_issue("t3.waw_bypass", 1, 1, 0);
        tick();
        check("t3.idle", 32'(MD_BUSY_O), 0);
        drive(1, 7, 0, 10, 0, 0, 0, 0, 1);
        check("t3.x7_set_wins", 32'(DEC_READY), 0);
        tick();
        check("t3.stray_done_err", 32'(MD_ERR), 0);
        check("t3.stray_done_busy", 32'(MD_BUSY_O), 0);
        drive(1, 7, 0, 10, 0, 0, 0, 0, 0);
        check("t3.x7_still_pending", 32'(DEC_READY), 0);
        drive(1, 7, 0, 10, 0, 0, 1, 7, 0);
        check("t3.x7_wb", 32'(DEC_READY), 1);
        do_reset();

        // 4: x0 destinations/sources never set pend or stall
        for (int i = 0; i < 100; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
            check("t4.addi_x0", 32'(ALU_ISSUE), 1);
            tick();
        end
        check("t4.no_stall", 32'(STALL_CNT), 0);
        drive(1, 0, 3, 4, 0, 0, 0, 0, 0);
        check("t4.rs1_zero", 32'(DEC_READY), 1);
        do_reset();

        // 5: watchdog fires 64 cycles after MD issue; reset clears everything
        drive(1, 0, 0, 3, 1, 0, 0, 0, 0);
        chk_issue("t5.md", 1, 0, 1);
        tick();
        idle();
        for (int i = 1; i < 64; i++) tick();
        check("t5.err_before", 32'(MD_ERR), 0);
        check("t5.busy_before", 32'(MD_BUSY_O), 1);
        tick();
        check("t5.err_at64", 32'(MD_ERR), 1);
        check("t5.busy_stays", 32'(MD_BUSY_O), 1);
        drive(1, 0, 0, 4, 0, 0, 0, 0, 0);
        chk_issue("t5.blocked", 0, 0, 0);
        RSTN = 1'b0;
        #1;
        check("t5.rst_err", 32'(MD_ERR), 0);
        check("t5.rst_busy", 32'(MD_BUSY_O), 0);
        check("t5.rst_stall", 32'(STALL_CNT), 0);
        tick();
        RSTN = 1'b1;
        drive(1, 3, 0, 4, 0, 0, 0, 0, 1);
        check("t5.pend_cleared", 32'(DEC_READY), 1);
        tick();
        check("t5.late_done_busy", 32'(MD_BUSY_O), 0);
        check("t5.late_done_err", 32'(MD_ERR), 0);
        do_reset();

        // 6: FLUSH blocks issue without counting; counter saturates at 15
        drive(1, 0, 0, 5, 0, 0, 0, 0, 0);
        tick();
        drive(1, 5, 0, 6, 0, 1, 0, 0, 0);
        chk_issue("t6.flush_hazard", 0, 0, 0);
        tick();
        check("t6.flush_nocount", 32'(STALL_CNT), 0);
        drive(1, 0, 0, 9, 0, 1, 0, 0, 0);
        chk_issue("t6.flush_clean", 0, 0, 0);
        tick();
        drive(1, 9, 0, 10, 0, 0, 0, 0, 0);
        check("t6.flush_no_pend", 32'(DEC_READY), 1);
        drive(1, 5, 0, 6, 0, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) tick();
        check("t6.stall14", 32'(STALL_CNT), 14);
        for (int i = 0; i < 6; i++) tick();
        check("t6.stall_sat", 32'(STALL_CNT), 15);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
